mrc_stage_pipe: RTL
===================

Name: mrc_stage_pipe

Overview:
- Parametrised, stallable mixed-radix-conversion (MRC) pipeline stage.
- Consumes one digit a_k (the current residue of modulus MOD_K) plus NUM_CH remaining residues r_j.
- Emits:
  - reduced residues r_j' = ((r_j - a_k) * INV_j) mod m_j;
  - weighted accumulator acc' = (acc + a_k*WEIGHT) mod MOD_OUT;
  - two updated dual-threshold sign codes.
- Cascades stage-to-stage via valid/ready to form an N-digit MRC/sign-detect chain for error-correcting RNS arithmetic.

Parameters:
- DATA_WIDTH, 18, width of every digit, residue and accumulator.
- NUM_CH, 4, number of remaining residue channels (1..16).
- MOD_K, 262103, modulus of the incoming digit.
- MOD_VEC, packed NUM_CH*DATA_WIDTH, channel moduli m_j; lane j at bits [j*DW +: DW].
- INV_VEC, packed NUM_CH*DATA_WIDTH, INV_j = MOD_K^-1 mod m_j.
- MOD_OUT, 262103, accumulator modulus.
- WEIGHT, 1, positional weight of this digit mod MOD_OUT.
- NEG_A / POS_A, 262078 / 0, sign thresholds, channel A.
- NEG_B / POS_B, 262078 / 0, sign thresholds, channel B.

Ports:
- clk, in, 1, clock.
- reset_n, in, 1, asynchronous active-low reset.
- in_valid, in, 1, input beat valid.
- in_ready, out, 1, stage can accept a beat.
- in_digit, in, DATA_WIDTH, a_k.
- in_res, in, NUM_CH*DATA_WIDTH, residues r_j.
- in_acc, in, DATA_WIDTH, accumulator.
- in_sgn_a / in_sgn_b, in, 2, incoming sign codes.
- out_valid, out, 1, output beat valid.
- out_ready, in, 1, downstream accepts.
- out_res, out, NUM_CH*DATA_WIDTH, r_j'.
- out_acc, out, DATA_WIDTH, acc'.
- out_sgn_a / out_sgn_b, out, 2, updated sign codes.
- out_err, out, 1, range error; present only with MRC_STAGE_RANGE_CHK_EN.

Behaviour:
- Reset (async assert, sync deassert use): all valids and all data/sign registers go to 0. Outputs read 0 and out_valid=0. Reset mid-operation discards in-flight beats.
- Pipeline: 3 registered stages, latency exactly 3 cycles from accepted beat to out_valid when unstalled.
  - S1: register inputs; compute d_j = (r_j - (a_k mod m_j)) mod m_j, adding m_j on borrow. Compute sign codes.
  - S2: compute p_j = d_j * INV_j (2*DW wide) and q = acc + a_k*WEIGHT.
  - S3: exact reduction p_j mod m_j and q mod MOD_OUT; results < modulus.
- Stall: en = !out_valid || out_ready. All stages advance only when en; in_ready = en (combinational).
  - Beat accepted when in_valid && in_ready.
  - Bubbles propagate as valid=0.
  - No bubble collapse inside the pipe.
- Backpressure: while out_valid && !out_ready, all outputs hold stable and in_ready=0.
- Full pipe with out_ready=1 and in_valid=1 sustains 1 beat/cycle with no loss or duplication.
- Sign codes (constants in package): UND=00, POS=01, NEG=10, ERR=11. Per channel X:
  - in_sgn==ERR -> ERR;
  - else a_k > NEG_X -> NEG;
  - else a_k > POS_X -> POS;
  - else pass in_sgn.
- Sign codes are delayed with the data; they must be coherent with the same beat.
- in_digit >= MOD_K is undefined without the optional feature.

Optional Feature:
- Macro MRC_STAGE_RANGE_CHK_EN.
- Defined: out_err port exists.
  - out_err is set for a beat if in_digit >= MOD_K or any r_j >= m_j.
  - When out_err is set, that beat's sign codes are forced to ERR.
  - The flag is carried aligned with the beat; it is not sticky.
- Undefined: no out_err port and no compare logic; the sign rule is as above.

Decomposition:
- Package mrc_pkg: sign code constants SGN_UND/POS/NEG/ERR; a function unpacking lane j from a packed parameter vector.
- One sub-module, mrc_lane_submul: per-channel sub/mul/reduce with 3 enable-gated stages, parameters MOD and INV, instantiated NUM_CH times via generate.
- Accumulator path and sign logic stay in the top.

Test Plan:
- Common params: DW=8, NUM_CH=2, MOD_K=7, MOD_VEC={13,11}, INV_VEC={2,8}, MOD_OUT=101, WEIGHT=15, NEG_A=5, POS_A=0.
- Basic: digit=3, r={10,5}, acc=50, sgn_a=UND -> 3 cycles later r'={1,5}, acc'=95, sgn_a=POS.
- Borrow/wrap: digit=6, r0=2, acc=90 -> r0'=1, acc'=79, sgn_a=NEG.
- Sign pass/ERR: digit=0 with sgn_a=NEG -> NEG; digit=6 with sgn_a=ERR -> ERR.
- Streaming/backpressure:
  - 10 back-to-back beats with out_ready toggling 1,0,0,1... -> every beat emitted once, in order, and outputs stable while stalled.
  - in_ready=0 only when out_valid=1 and out_ready=0.
- Reset: assert reset_n=0 with 3 beats in flight -> out_valid=0 and all outputs 0 immediately; after release, a new beat emerges at cycle 3.
- With MRC_STAGE_RANGE_CHK_EN: digit=7 -> out_err=1, sgn_a=sgn_b=ERR; next beat digit=2 -> out_err=0.

Source files
------------

// File: rtl/mrc_pkg.sv
// Shared definitions for the mixed-radix-conversion stage: sign codes and a
// helper that extracts one lane from a packed per-channel parameter vector.
package mrc_pkg;

    localparam logic [1:0] SGN_UND = 2'b00;
    localparam logic [1:0] SGN_POS = 2'b01;
    localparam logic [1:0] SGN_NEG = 2'b10;
    localparam logic [1:0] SGN_ERR = 2'b11;

    // Widest packed vector / lane the helper accepts (16 channels x 64 bits).
    localparam int unsigned VEC_W  = 1024;
    localparam int unsigned LANE_W = 64;

    function automatic logic [LANE_W-1:0] lane_of(input logic [VEC_W-1:0] vec,
                                                  input int unsigned lane,
                                                  input int unsigned dw);
        logic [LANE_W-1:0] mask;
        mask = (dw >= LANE_W) ? '1 : ((LANE_W'(1) << dw) - LANE_W'(1));
        return LANE_W'(vec >> (lane * dw)) & mask;
    endfunction

endpackage

// File: rtl/mrc_lane_submul.sv
// One residue channel of the MRC stage: subtract the digit, multiply by the
// inverse of MOD_K, reduce mod MOD. Three enable-gated register stages.
module mrc_lane_submul
    import mrc_pkg::*;
#(
    parameter int unsigned   DW    = 18,
    parameter int unsigned   MOD_K = 262103,
    parameter logic [DW-1:0] MOD   = DW'(3),
    parameter logic [DW-1:0] INV   = DW'(2)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          en_i,
    input  logic [DW-1:0] digit_i,
    input  logic [DW-1:0] res_i,
    output logic [DW-1:0] res_o
);

    logic [DW-1:0]   ak_mod;
    logic [DW-1:0]   d_d, d_q;
    logic [2*DW-1:0] p_d, p_q;
    logic [DW-1:0]   r_d, r_q;

    // A legal digit is already below MOD when MOD_K <= MOD, so no fold is needed.
    if (MOD_K <= 32'(MOD)) begin : g_no_fold
        assign ak_mod = digit_i;
    end else begin : g_fold
        assign ak_mod = digit_i % MOD;
    end

    always_comb begin
        if (res_i >= ak_mod) begin
            d_d = res_i - ak_mod;
        end else begin
            d_d = DW'({1'b0, res_i} + {1'b0, MOD} - {1'b0, ak_mod});
        end
        p_d = {{DW{1'b0}}, d_q} * {{DW{1'b0}}, INV};
        r_d = DW'(p_q % {{DW{1'b0}}, MOD});
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            d_q <= '0;
            p_q <= '0;
            r_q <= '0;
        end else if (en_i) begin
            d_q <= d_d;
            p_q <= p_d;
            r_q <= r_d;
        end
    end

    assign res_o = r_q;

endmodule

// File: rtl/mrc_stage_pipe.sv
// Stallable 3-stage MRC pipeline stage: residue lanes, weighted accumulator
// and dual-threshold sign codes. Optional range check: MRC_STAGE_RANGE_CHK_EN.
module mrc_stage_pipe
    import mrc_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 18,
    parameter int unsigned NUM_CH     = 4,
    parameter int unsigned MOD_K      = 262103,
    parameter logic [NUM_CH*DATA_WIDTH-1:0] MOD_VEC = {18'd163, 18'd67, 18'd8, 18'd3},
    parameter logic [NUM_CH*DATA_WIDTH-1:0] INV_VEC = {18'd162, 18'd66, 18'd7, 18'd2},
    parameter int unsigned MOD_OUT    = 262103,
    parameter int unsigned WEIGHT     = 1,
    parameter int unsigned NEG_A      = 262078,
    parameter int unsigned POS_A      = 0,
    parameter int unsigned NEG_B      = 262078,
    parameter int unsigned POS_B      = 0
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [DATA_WIDTH-1:0]        in_digit,
    input  logic [NUM_CH*DATA_WIDTH-1:0] in_res,
    input  logic [DATA_WIDTH-1:0]        in_acc,
    input  logic [1:0]                   in_sgn_a,
    input  logic [1:0]                   in_sgn_b,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [NUM_CH*DATA_WIDTH-1:0] out_res,
    output logic [DATA_WIDTH-1:0]        out_acc,
    output logic [1:0]                   out_sgn_a,
    output logic [1:0]                   out_sgn_b
`ifdef MRC_STAGE_RANGE_CHK_EN
    ,
    output logic                         out_err
`endif
);

    localparam int unsigned DW = DATA_WIDTH;
    localparam int unsigned QW = 2 * DW + 1;
    localparam logic [DW-1:0] NEG_A_W   = DW'(NEG_A);
    localparam logic [DW-1:0] POS_A_W   = DW'(POS_A);
    localparam logic [DW-1:0] NEG_B_W   = DW'(NEG_B);
    localparam logic [DW-1:0] POS_B_W   = DW'(POS_B);
    localparam logic [DW-1:0] WEIGHT_W  = DW'(WEIGHT);
    localparam logic [QW-1:0] MOD_OUT_Q = QW'(MOD_OUT);

    // Handshake: a beat moves on a clock edge when valid && ready. The whole
    // pipe advances together on en; in_ready is en, so a stalled output
    // freezes every stage and bubbles travel as valid=0 without collapsing.
    logic en;
    logic v1_q, v2_q, v3_q;

    assign en        = !v3_q || out_ready;
    assign in_ready  = en;
    assign out_valid = v3_q;

    function automatic logic [1:0] sgn_rule(input logic [1:0] sgn, input logic gt_neg,
                                            input logic gt_pos);
        if (sgn == SGN_ERR) return SGN_ERR;
        if (gt_neg)         return SGN_NEG;
        if (gt_pos)         return SGN_POS;
        return sgn;
    endfunction

    logic [DW-1:0] dig_s1_q, acc_s1_q;
    logic [1:0]    sa_d, sb_d, sa_s1_q, sb_s1_q, sa_s2_q, sb_s2_q, sa_s3_q, sb_s3_q;
    logic [QW-1:0] q_d, q_s2_q;
    logic [DW-1:0] acc_d, acc_s3_q;

`ifdef MRC_STAGE_RANGE_CHK_EN
    logic [NUM_CH-1:0] res_oor;
    logic              err_d, err_s1_q, err_s2_q, err_s3_q;
    assign err_d = ({1'b0, in_digit} >= (DW+1)'(MOD_K)) || (|res_oor);
`endif

    for (genvar j = 0; j < NUM_CH; j++) begin : g_lane
        localparam logic [DW-1:0] LMOD = DW'(lane_of(VEC_W'(MOD_VEC), j, DW));
        localparam logic [DW-1:0] LINV = DW'(lane_of(VEC_W'(INV_VEC), j, DW));

        mrc_lane_submul #(
            .DW    (DW),
            .MOD_K (MOD_K),
            .MOD   (LMOD),
            .INV   (LINV)
        ) u_lane (
            .clk     (clk),
            .reset_n (reset_n),
            .en_i    (en),
            .digit_i (in_digit),
            .res_i   (in_res[j*DW +: DW]),
            .res_o   (out_res[j*DW +: DW])
        );

`ifdef MRC_STAGE_RANGE_CHK_EN
        assign res_oor[j] = in_res[j*DW +: DW] >= LMOD;
`endif
    end

    always_comb begin
        sa_d = sgn_rule(in_sgn_a, in_digit > NEG_A_W, in_digit > POS_A_W);
        sb_d = sgn_rule(in_sgn_b, in_digit > NEG_B_W, in_digit > POS_B_W);
`ifdef MRC_STAGE_RANGE_CHK_EN
        if (err_d) begin
            sa_d = SGN_ERR;
            sb_d = SGN_ERR;
        end
`endif
        q_d   = QW'(acc_s1_q) + QW'({{DW{1'b0}}, dig_s1_q} * {{DW{1'b0}}, WEIGHT_W});
        acc_d = DW'(q_s2_q % MOD_OUT_Q);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            v1_q     <= 1'b0;
            v2_q     <= 1'b0;
            v3_q     <= 1'b0;
            dig_s1_q <= '0;
            acc_s1_q <= '0;
            sa_s1_q  <= '0;
            sb_s1_q  <= '0;
            q_s2_q   <= '0;
            sa_s2_q  <= '0;
            sb_s2_q  <= '0;
            acc_s3_q <= '0;
            sa_s3_q  <= '0;
            sb_s3_q  <= '0;
        end else if (en) begin
            v1_q     <= in_valid;
            v2_q     <= v1_q;
            v3_q     <= v2_q;
            dig_s1_q <= in_digit;
            acc_s1_q <= in_acc;
            sa_s1_q  <= sa_d;
            sb_s1_q  <= sb_d;
            q_s2_q   <= q_d;
            sa_s2_q  <= sa_s1_q;
            sb_s2_q  <= sb_s1_q;
            acc_s3_q <= acc_d;
            sa_s3_q  <= sa_s2_q;
            sb_s3_q  <= sb_s2_q;
        end
    end

`ifdef MRC_STAGE_RANGE_CHK_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_s1_q <= 1'b0;
            err_s2_q <= 1'b0;
            err_s3_q <= 1'b0;
        end else if (en) begin
            err_s1_q <= err_d;
            err_s2_q <= err_s1_q;
            err_s3_q <= err_s2_q;
        end
    end

    assign out_err = err_s3_q;
`endif

    assign out_acc   = acc_s3_q;
    assign out_sgn_a = sa_s3_q;
    assign out_sgn_b = sb_s3_q;

endmodule
